// File: rtl/des3_ctrl.sv
// des3_ctrl: Triple-DES sequencer that runs a single DES core three times per block
// (E-D-E to encrypt, D-E-D to decrypt) with per-pass error and timeout abort.
module des3_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [63:0]  s_data_in,
  input  logic [191:0] s_key_in,
  input  logic         s_mode_in,
  input  logic         s_verify_in,
  input  logic         s_valid_in,
  output logic         s_ready_out,
  output logic [63:0]  m_data_out,
  output logic         m_err_out,
  output logic         m_valid_out,
  input  logic         m_ready_in,
  output logic [63:0]  core_data_out,
  output logic [63:0]  core_key_out,
  output logic         core_mode_out,
  output logic         core_verify_out,
  output logic         core_valid_out,
  input  logic         core_ready_in,
  input  logic [63:0]  core_data_in,
  input  logic         core_valid_in,
  input  logic         core_err_in,
  output logic         busy_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYC);
  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYC != 0);

  state_t      state_q, state_d;
  logic [63:0] work_q;
  logic [63:0] k1_q, k2_q, k3_q;
  logic        mode_q, verify_q, err_q;
  logic [1:0]  pass_q;
  logic [15:0] tcnt_q, tcnt_inc;
  logic        timeout_hit;

  // Timeout fires in the WAIT cycle that would bring the count up to the limit.
  assign tcnt_inc    = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
  assign timeout_hit = TIMEOUT_EN && ({1'b0, tcnt_inc} >= TIMEOUT_LIM);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (s_valid_in) state_d = ISSUE;
      ISSUE: if (core_ready_in) state_d = WAIT;
      WAIT: begin
        if (core_err_in)        state_d = DONE;
        else if (core_valid_in) state_d = (pass_q == 2'd2) ? DONE : ISSUE;
        else if (timeout_hit)   state_d = DONE;
      end
      DONE:  if (m_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      work_q   <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      k3_q     <= '0;
      mode_q   <= 1'b0;
      verify_q <= 1'b0;
      err_q    <= 1'b0;
      pass_q   <= 2'd0;
      tcnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (s_valid_in) begin
          work_q   <= s_data_in;
          k1_q     <= s_key_in[191:128];
          k2_q     <= s_key_in[127:64];
          k3_q     <= s_key_in[63:0];
          mode_q   <= s_mode_in;
          verify_q <= s_verify_in;
          err_q    <= 1'b0;
          pass_q   <= 2'd0;
        end
        ISSUE: if (core_ready_in) tcnt_q <= '0;
        WAIT: begin
          if (core_err_in) begin
            err_q  <= 1'b1;
            work_q <= core_data_in;
          end else if (core_valid_in) begin
            work_q <= core_data_in;
            if (pass_q != 2'd2) pass_q <= pass_q + 2'd1;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Middle pass always uses K2 with the opposite direction of the outer passes.
  always_comb begin
    core_key_out = k1_q;
    case (pass_q)
      2'd0:    core_key_out = mode_q ? k3_q : k1_q;
      2'd1:    core_key_out = k2_q;
      default: core_key_out = mode_q ? k1_q : k3_q;
    endcase
    core_mode_out   = mode_q ^ (pass_q == 2'd1);
    core_data_out   = work_q;
    core_verify_out = verify_q;
    core_valid_out  = (state_q == ISSUE) && core_ready_in;
    s_ready_out     = (state_q == IDLE) && !rst_in;
    m_valid_out     = (state_q == DONE);
    m_data_out      = work_q;
    m_err_out       = err_q;
    busy_out        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_des3_ctrl.sv
// tb_des3_ctrl: drives des3_ctrl against a behavioural DES core and checks results
// against a pass-by-pass triple-DES reference built on a plain DES function.
module tb_des3_ctrl;
  localparam int TO = 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [63:0]  s_data_in;
  logic [191:0] s_key_in;
  logic         s_mode_in, s_verify_in, s_valid_in, s_ready_out;
  logic [63:0]  m_data_out;
  logic         m_err_out, m_valid_out, m_ready_in;
  logic [63:0]  core_data_out, core_key_out, core_data_in;
  logic         core_mode_out, core_verify_out, core_valid_out, core_ready_in;
  logic         core_valid_in, core_err_in, busy_out;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  des3_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_data_in(s_data_in), .s_key_in(s_key_in), .s_mode_in(s_mode_in),
    .s_verify_in(s_verify_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .m_data_out(m_data_out), .m_err_out(m_err_out), .m_valid_out(m_valid_out),
    .m_ready_in(m_ready_in), .core_data_out(core_data_out), .core_key_out(core_key_out),
    .core_mode_out(core_mode_out), .core_verify_out(core_verify_out),
    .core_valid_out(core_valid_out), .core_ready_in(core_ready_in),
    .core_data_in(core_data_in), .core_valid_in(core_valid_in),
    .core_err_in(core_err_in), .busy_out(busy_out)
  );

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
    46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] des_blk(input logic [63:0] blk, input logic [63:0] key,
                                          input logic dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [63:0] pm, pre, res;
    logic [31:0] l, r, f, sout, t;
    logic [5:0]  six;
    logic [3:0]  sv4;
    int row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SHIFT_T[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) pm[63-i] = blk[64-IP_T[i]];
    l = pm[63:32];
    r = pm[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-(((4*(i/6) + i%6 + 31) % 32) + 1)];
      e = e ^ (dec ? ks[15-rd] : ks[rd]);
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        row = 2*int'(six[5]) + int'(six[0]);
        col = int'(six[4:1]);
        sv4 = 4'(SBOX_T[s*64 + row*16 + col]);
        sout[31-4*s -: 4] = sv4;
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
      t = l ^ f;
      l = r;
      r = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  function automatic bit parity_ok(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] o = k;
    for (int b = 0; b < 8; b++) o[8*b] = ~^k[8*b+1 +: 7];
    return o;
  endfunction

  // Schedule as listed: encrypt K1/0,K2/1,K3/0; decrypt K3/1,K2/0,K1/1.
  function automatic logic [63:0] sched_key(input logic [191:0] k, input logic mode, input int p);
    logic [63:0] enc_keys [3];
    logic [63:0] dec_keys [3];
    enc_keys = '{k[191:128], k[127:64], k[63:0]};
    dec_keys = '{k[63:0], k[127:64], k[191:128]};
    return mode ? dec_keys[p] : enc_keys[p];
  endfunction

  function automatic logic sched_mode(input logic mode, input int p);
    logic [2:0] pat;
    pat = mode ? 3'b101 : 3'b010;
    return pat[2-p];
  endfunction

  // The bench core answers an error with the inverted input block.
  task automatic ref_3des(input logic [63:0] d, input logic [191:0] k, input logic mode,
                          input logic verify, output logic [63:0] od, output logic oe,
                          output int np);
    od = d;
    oe = 1'b0;
    np = 3;
    for (int p = 0; p < 3; p++) begin
      if (verify && !parity_ok(sched_key(k, mode, p))) begin
        od = ~od;
        oe = 1'b1;
        np = p + 1;
        return;
      end
      od = des_blk(od, sched_key(k, mode, p), sched_mode(mode, p));
    end
  endtask

  int lc = 2;
  bit core_mute = 1'b0;
  bit core_flush = 1'b0;
  bit core_inject = 1'b0;
  logic [63:0] inject_data = '0;
  logic [63:0] q_key [$];
  logic        q_mode [$];
  logic [63:0] q_data [$];

  // Behavioural DES core: samples requests mid-cycle and answers lc cycles later.
  initial begin
    int pend;
    logic [63:0] pend_out;
    logic pend_err;
    pend = 0;
    pend_out = '0;
    pend_err = 1'b0;
    core_valid_in = 1'b0;
    core_err_in = 1'b0;
    core_data_in = '0;
    forever begin
      @(negedge clk_in);
      #1;
      core_valid_in = 1'b0;
      core_err_in = 1'b0;
      if (core_flush) begin
        pend = 0;
        core_flush = 1'b0;
      end
      if (core_inject) begin
        core_valid_in = 1'b1;
        core_data_in = inject_data;
        core_inject = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_data_in = pend_out;
          if (pend_err) begin
            core_err_in = 1'b1;
            core_valid_in = 1'($urandom_range(0, 1));
          end else begin
            core_valid_in = 1'b1;
          end
        end
      end
      if (core_valid_out) begin
        q_key.push_back(core_key_out);
        q_mode.push_back(core_mode_out);
        q_data.push_back(core_data_out);
        if (!core_mute) begin
          pend = lc;
          pend_err = core_verify_out && !parity_ok(core_key_out);
          pend_out = pend_err ? ~core_data_out
                              : des_blk(core_data_out, core_key_out, core_mode_out);
        end
      end
    end
  end

  task automatic run_req(input string tag, input logic [63:0] d, input logic [191:0] k,
                         input logic mode, input logic verify, input bit early,
                         input int hold, output logic [63:0] got);
    logic [63:0] ed;
    logic ee;
    int np, n;
    ref_3des(d, k, mode, verify, ed, ee, np);
    got = '0;
    @(negedge clk_in);
    q_key.delete();
    q_mode.delete();
    q_data.delete();
    s_data_in = d;
    s_key_in = k;
    s_mode_in = mode;
    s_verify_in = verify;
    s_valid_in = 1'b1;
    m_ready_in = early;
    n = 0;
    while (!s_ready_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (s_ready_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s accept: s_ready=%b required 1", tag, s_ready_out);
      s_valid_in = 1'b0;
      return;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    s_valid_in = 1'b0;
    n = 1;
    while (!m_valid_out && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (m_valid_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s result timeout: m_valid=%b required 1", tag, m_valid_out);
      m_ready_in = 1'b0;
      return;
    end
    got = m_data_out;
    total++;
    if (m_data_out !== ed) begin
      bad++;
      $display("[TB] FAIL %s data: got %h required %h", tag, m_data_out, ed);
    end
    total++;
    if (m_err_out !== ee) begin
      bad++;
      $display("[TB] FAIL %s err: got %b required %b", tag, m_err_out, ee);
    end
    total++;
    if (n != 1 + np * (1 + lc)) begin
      bad++;
      $display("[TB] FAIL %s latency: got %0d required %0d", tag, n, 1 + np * (1 + lc));
    end
    total++;
    if (s_ready_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s ready in done: got %b required 0", tag, s_ready_out);
    end
    total++;
    if (q_key.size() != np) begin
      bad++;
      $display("[TB] FAIL %s issue count: got %0d required %0d", tag, q_key.size(), np);
    end
    if (q_data.size() > 0) begin
      total++;
      if (q_data[0] !== d) begin
        bad++;
        $display("[TB] FAIL %s first core data: got %h required %h", tag, q_data[0], d);
      end
    end
    for (int p = 0; p < q_key.size() && p < np; p++) begin
      total++;
      if (q_key[p] !== sched_key(k, mode, p) || q_mode[p] !== sched_mode(mode, p)) begin
        bad++;
        $display("[TB] FAIL %s pass %0d key/mode: got %h/%b required %h/%b", tag, p,
                 q_key[p], q_mode[p], sched_key(k, mode, p), sched_mode(mode, p));
      end
    end
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_in);
        total++;
        if (m_valid_out !== 1'b1 || m_data_out !== ed || m_err_out !== ee || s_ready_out !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s hold %0d: v/e/rdy/data=%b/%b/%b/%h required 1/%b/0/%h",
                   tag, i, m_valid_out, m_err_out, s_ready_out, m_data_out, ee, ed);
        end
      end
    end
    m_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    m_ready_in = 1'b0;
    total++;
    if (s_ready_out !== 1'b1 || m_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s release: rdy/valid/busy=%b/%b/%b required 1/0/0", tag,
               s_ready_out, m_valid_out, busy_out);
    end
  endtask

  task automatic check_reset_vals(input string tag, input logic rdy);
    total++;
    if ({m_valid_out, m_err_out, m_data_out, core_valid_out, core_data_out, core_key_out,
         core_mode_out, core_verify_out, busy_out, s_ready_out} !== {197'd0, rdy}) begin
      bad++;
      $display("[TB] FAIL %s: v=%b e=%b d=%h cv=%b cd=%h ck=%h cm=%b cvf=%b busy=%b rdy=%b required zeros, rdy=%b",
               tag, m_valid_out, m_err_out, m_data_out, core_valid_out, core_data_out,
               core_key_out, core_mode_out, core_verify_out, busy_out, s_ready_out, rdy);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    #2;
    check_reset_vals("reset values", 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_reset_vals("idle after reset", 1'b1);
  endtask

  task automatic test_kat;
    logic [63:0] got;
    lc = 2;
    run_req("kat", 64'h0123456789ABCDEF, {3{64'h133457799BBCDFF1}}, 1'b0, 1'b1, 1'b0, 0, got);
    total++;
    if (got !== 64'h85E813540F0AB405) begin
      bad++;
      $display("[TB] FAIL kat known answer: got %h required 85e813540f0ab405", got);
    end
  endtask

  task automatic test_round_trip;
    logic [191:0] k;
    logic [63:0] ct, pt;
    k = {64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123};
    lc = 1;
    run_req("rt enc", 64'h5468652071756663, k, 1'b0, 1'b0, 1'b0, 0, ct);
    lc = 3;
    run_req("rt dec", ct, k, 1'b1, 1'b0, 1'b1, 0, pt);
    total++;
    if (pt !== 64'h5468652071756663) begin
      bad++;
      $display("[TB] FAIL round trip: got %h required 5468652071756663", pt);
    end
  endtask

  task automatic test_parity;
    logic [63:0] got;
    lc = 2;
    run_req("parity", 64'h0123456789ABCDEF,
            {64'h133457799BBCDFF0, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1},
            1'b0, 1'b1, 1'b0, 0, got);
  endtask

  task automatic test_backpressure;
    logic [63:0] got;
    lc = 2;
    run_req("backpressure", 64'hFEDCBA9876543210,
            {64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123},
            1'b1, 1'b0, 1'b0, 10, got);
  endtask

  task automatic test_stall_timeout;
    logic [63:0] d;
    int n;
    d = 64'hA5A5_1234_5A5A_9876;
    @(negedge clk_in);
    q_key.delete();
    q_mode.delete();
    q_data.delete();
    core_ready_in = 1'b0;
    core_mute = 1'b1;
    s_data_in = d;
    s_key_in = {64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123};
    s_mode_in = 1'b0;
    s_verify_in = 1'b1;
    s_valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    s_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      total++;
      if (core_valid_out !== 1'b0 || busy_out !== 1'b1 || q_key.size() != 0) begin
        bad++;
        $display("[TB] FAIL stall cycle %0d: core_valid=%b busy=%b issues=%0d required 0/1/0",
                 i, core_valid_out, busy_out, q_key.size());
      end
      @(negedge clk_in);
    end
    total++;
    if (core_data_out !== d || core_key_out !== 64'h0123456789ABCDEF ||
        core_mode_out !== 1'b0 || core_verify_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall drive: data/key/mode/verify=%h/%h/%b/%b required %h/0123456789abcdef/0/1",
               core_data_out, core_key_out, core_mode_out, core_verify_out, d);
    end
    core_ready_in = 1'b1;
    n = 0;
    while (!m_valid_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (n != TO + 1 || m_err_out !== 1'b1 || m_data_out !== d || q_key.size() != 1) begin
      bad++;
      $display("[TB] FAIL timeout: cycles=%0d err=%b data=%h issues=%0d required %0d/1/%h/1",
               n, m_err_out, m_data_out, q_key.size(), TO + 1, d);
    end
    core_mute = 1'b0;
    m_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    m_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [191:0] k;
    logic [63:0] got;
    int n;
    lc = 3;
    k = {fix_parity({$urandom, $urandom}), fix_parity({$urandom, $urandom}),
         fix_parity({$urandom, $urandom})};
    @(negedge clk_in);
    q_key.delete();
    q_mode.delete();
    q_data.delete();
    s_data_in = {$urandom, $urandom};
    s_key_in = k;
    s_mode_in = 1'b0;
    s_verify_in = 1'b0;
    s_valid_in = 1'b1;
    m_ready_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    s_valid_in = 1'b0;
    n = 0;
    #2;
    while (q_key.size() < 2 && n < 100) begin
      @(negedge clk_in);
      #2;
      n++;
    end
    total++;
    if (q_key.size() != 2) begin
      bad++;
      $display("[TB] FAIL mid reset reach pass 1: issues=%0d required 2", q_key.size());
    end
    @(negedge clk_in);
    core_flush = 1'b1;
    rst_in = 1'b1;
    #1;
    check_reset_vals("mid reset values", 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    inject_data = {$urandom, $urandom};
    core_inject = 1'b1;
    @(negedge clk_in);
    #2;
    check_reset_vals("stale response ignored", 1'b1);
    run_req("post reset", {$urandom, $urandom}, k, 1'b1, 1'b0, 1'b0, 0, got);
  endtask

  task automatic test_random;
    logic [191:0] k;
    logic [63:0] got;
    int idx;
    for (int it = 0; it < 16; it++) begin
      k = {fix_parity({$urandom, $urandom}), fix_parity({$urandom, $urandom}),
           fix_parity({$urandom, $urandom})};
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 2);
        k[64*idx] = ~k[64*idx];
      end
      lc = $urandom_range(1, 4);
      run_req($sformatf("random %0d", it), {$urandom, $urandom}, k, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    s_valid_in = 1'b0;
    s_data_in = '0;
    s_key_in = '0;
    s_mode_in = 1'b0;
    s_verify_in = 1'b0;
    m_ready_in = 1'b0;
    core_ready_in = 1'b1;
    test_reset;
    test_kat;
    test_round_trip;
    test_parity;
    test_backpressure;
    test_stall_timeout;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
